// File: rtl/delay_line_ctrl.sv
// Handshake controller for a ce-gated fixed-depth shift buffer: owns the buffer's ce,
// tracks which stages hold real tokens and supports a drain-only flush mode.
module delay_line_ctrl #(
    parameter int DATA_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic                 flush_i,
    output logic                 ce_o,
    output logic [CNT_WIDTH-1:0] occupancy_o,
    output logic                 busy_o,
    output logic                 flush_done_o
);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [DATA_DEPTH-1:0] vld_q, vld_d;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  done_q, done_d;
    logic                  advance, accept, emit;

    // The line may move whenever the output stage is a bubble or is being consumed.
    assign advance     = ~vld_q[DATA_DEPTH-1] | out_ready_i;
    assign ce_o        = advance & ~rst;
    assign out_valid_o = vld_q[DATA_DEPTH-1];
    assign accept      = in_valid_i & in_ready_o;
    assign emit        = out_valid_o & out_ready_i;

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            RUN: begin
                in_ready_o = advance & ~rst;
                if (flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                busy_o = 1'b1;
                if (occ_q == '0) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    generate
        if (DATA_DEPTH == 1) begin : g_d1
            assign vld_d = ce_o ? accept : vld_q;
        end else begin : g_dn
            assign vld_d = ce_o ? {vld_q[DATA_DEPTH-2:0], accept} : vld_q;
        end
    endgenerate

    always_comb begin
        occ_d = occ_q;
        case ({accept, emit})
            2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
            2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            vld_q   <= '0;
            occ_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
        end
    end

    assign occupancy_o  = occ_q;
    assign flush_done_o = done_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: a depth-4 and a depth-1 instance, each driving a model of the
// external shift buffer, with a token scoreboard checking order and occupancy.
module tb_delay_line_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // depth-4 instance
    logic       in_valid = 0, out_ready = 0, flush = 0;
    logic [7:0] din = 0;
    logic       in_ready, out_valid, ce, busy, flush_done;
    logic [2:0] occupancy;

    delay_line_ctrl #(.DATA_DEPTH(4), .CNT_WIDTH(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .flush_i(flush), .ce_o(ce),
        .occupancy_o(occupancy), .busy_o(busy), .flush_done_o(flush_done));

    logic [7:0] bm [4];
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 4; i++) bm[i] <= '0;
        else if (ce) begin
            bm[0] <= din;
            for (int i = 1; i < 4; i++) bm[i] <= bm[i-1];
        end
    end

    // depth-1 instance
    logic       d1_in_valid = 0, d1_out_ready = 0, d1_flush = 0;
    logic [7:0] d1_din = 0, d1_bm;
    logic       d1_in_ready, d1_out_valid, d1_ce, d1_busy, d1_flush_done;
    logic [0:0] d1_occ;

    delay_line_ctrl #(.DATA_DEPTH(1), .CNT_WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid_i(d1_in_valid), .in_ready_o(d1_in_ready),
        .out_valid_o(d1_out_valid), .out_ready_i(d1_out_ready), .flush_i(d1_flush), .ce_o(d1_ce),
        .occupancy_o(d1_occ), .busy_o(d1_busy), .flush_done_o(d1_flush_done));

    always @(posedge clk) begin
        if (rst) d1_bm <= '0;
        else if (d1_ce) d1_bm <= d1_din;
    end

    // scoreboards: push on accept, pop and compare on emit
    logic [7:0] sb [$];
    logic [7:0] sb1 [$];

    always @(negedge clk) begin
        #1;
        if (rst) begin
            sb.delete();
            sb1.delete();
        end else begin
            chk("occ", occupancy, sb.size());
            if (in_valid && in_ready) sb.push_back(din);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("emit_empty", 1, 0);
                else chk("data", bm[3], sb.pop_front());
            end
            chk("d1_occ", d1_occ, sb1.size());
            if (d1_in_valid && d1_in_ready) sb1.push_back(d1_din);
            if (d1_out_valid && d1_out_ready) begin
                if (sb1.size() == 0) chk("d1_emit_empty", 1, 0);
                else chk("d1_data", d1_bm, sb1.pop_front());
            end
        end
    end

    task automatic tick(input logic r, input logic iv, input logic [7:0] d,
                        input logic ordy, input logic fl);
        @(negedge clk);
        rst = r; in_valid = iv; din = d; out_ready = ordy; flush = fl;
        #2;
    endtask

    task automatic tick1(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        d1_in_valid = iv; d1_din = d; d1_out_ready = ordy;
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) tick(0, 0, 8'd0, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout act=0 exp=1");
        $fatal(1);
    end

    initial begin
        logic ov_m, exp_ir;

        // reset behaviour
        tick(1, 1, 8'd9, 1, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ce", ce, 0);
        tick(1, 1, 8'd9, 1, 0);
        tick(0, 0, 8'd0, 0, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", flush_done, 0);
        chk("rst_ir", in_ready, 1);

        // stream 1..10
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1, 8'(i), 1, 0);
            chk("strm_ov", out_valid, (i >= 5));
            chk("strm_occ", occupancy, (i > 4) ? 4 : i - 1);
            chk("strm_ce", ce, 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 8'd0, 1, 0);
            chk("strm_tail_ov", out_valid, 1);
        end
        tick(0, 0, 8'd0, 1, 0);
        chk("strm_empty_ov", out_valid, 0);

        // backpressure
        for (int k = 0; k < 4; k++) tick(0, 1, 8'(20 + k), 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 8'd99, 0, 0);
            chk("bp_ce", ce, 0);
            chk("bp_ir", in_ready, 0);
            chk("bp_occ", occupancy, 4);
            chk("bp_dout", bm[3], 20);
        end
        drain();

        // bubble squeeze
        tick(0, 1, 8'd30, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        tick(0, 1, 8'd31, 0, 0);
        chk("bub_ce_adv", ce, 1);
        tick(0, 0, 8'd0, 0, 0);
        chk("bub_occ", occupancy, 2);
        chk("bub_ov", out_valid, 1);
        chk("bub_ce", ce, 0);
        chk("bub_dout", bm[3], 30);
        drain();

        // flush with 3 in flight plus the flush-cycle token
        for (int k = 0; k < 3; k++) tick(0, 1, 8'(40 + k), 1, 0);
        tick(0, 1, 8'd43, 1, 1);
        chk("fl_accept", in_ready, 1);
        for (int n = 0; n < 8; n++) begin
            tick(0, 1, 8'(50 + n), 1, (n < 2));
            chk("fl_busy", busy, (n < 5));
            chk("fl_ir", in_ready, (n >= 5));
            chk("fl_done", flush_done, (n == 5));
        end
        drain();

        // empty flush
        tick(0, 0, 8'd0, 1, 1);
        tick(0, 0, 8'd0, 1, 0);
        chk("ef_busy1", busy, 1);
        tick(0, 0, 8'd0, 1, 0);
        chk("ef_busy2", busy, 0);
        chk("ef_done", flush_done, 1);
        tick(0, 0, 8'd0, 1, 0);
        chk("ef_done_once", flush_done, 0);

        // reset mid-flush with 2 tokens
        tick(0, 1, 8'd60, 1, 0);
        tick(0, 1, 8'd61, 1, 1);
        tick(0, 0, 8'd0, 1, 0);
        chk("rf_busy", busy, 1);
        chk("rf_occ", occupancy, 2);
        tick(1, 0, 8'd0, 1, 0);
        chk("rf_rst_ir", in_ready, 0);
        chk("rf_rst_ce", ce, 0);
        tick(0, 0, 8'd0, 0, 0);
        chk("rf_occ0", occupancy, 0);
        chk("rf_ov0", out_valid, 0);
        chk("rf_busy0", busy, 0);
        chk("rf_fd0", flush_done, 0);
        chk("rf_ir", in_ready, 1);
        tick(0, 0, 8'd0, 0, 0);
        chk("rf_fd1", flush_done, 0);

        // depth-1 with alternating out_ready
        ov_m = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_ir = !ov_m || i[0];
            tick1(1, 8'(80 + i), i[0]);
            chk("d1_ov", d1_out_valid, ov_m);
            chk("d1_ir", d1_in_ready, exp_ir);
            if (exp_ir) ov_m = 1'b1;
        end
        tick1(0, 8'd0, 1);
        tick1(0, 8'd0, 1);
        chk("d1_drained", d1_out_valid, 0);

        tick(0, 0, 8'd0, 0, 0);
        chk("sb_left", sb.size(), 0);
        chk("sb1_left", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
